mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter sharing the single-port main memory between the instruction-fetch (IF) port and the load/store (LS) port. It grants one requester per transaction and drives the memory's address, write-enable and write-data lines. Byte and halfword stores are performed as two-cycle read-modify-write sequences, because the memory only writes whole 32-bit words. Loads are returned sign- or zero-extended.

## Interface
- STARVE_LIMIT, default 3: consecutive IF losses after which IF gets forced priority.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_if_req  in  1  IF request; held with i_if_addr stable until o_if_ack.
- i_if_addr  in  32  IF byte address.
- o_if_ack  out  1  one-cycle pulse; o_if_rdata valid this cycle.
- o_if_rdata  out  32  fetched word.
- i_ls_req  in  1  LS request; inputs held stable until o_ls_ack.
- i_ls_addr  in  32  LS byte address.
- i_ls_wr_en  in  1  1 = store, 0 = load.
- i_ls_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- i_ls_unsigned  in  1  for loads: zero-extend when 1, sign-extend when 0.
- i_ls_wr_val  in  32  store data; only the low bytes are used for sub-word stores.
- o_ls_ack  out  1  one-cycle completion pulse.
- o_ls_rdata  out  32  extended load result.
- o_mem_addr  out  32  memory address.
- o_mem_wr_en  out  1  memory write enable.
- o_mem_wr_val  out  32  memory write word.
- i_mem_val  in  32  memory read word; combinational from o_mem_addr.

## Operation
- States: IDLE, RMW_WR, RESP. Reset value: IDLE.
- **IDLE, no request:**
  - o_mem_wr_en=0.
  - o_mem_addr = i_if_addr.
- **IDLE arbitration:**
  - LS wins by default.
  - IF wins when i_if_req=1 and starve_cnt ≥ STARVE_LIMIT.
- **starve_cnt:**
  - 2 bits wide, saturating.
  - Increments when IF requests in IDLE and loses.
  - Clears when IF is granted.
- **IDLE, IF granted:**
  - o_mem_addr = i_if_addr.
  - i_mem_val is registered into o_if_rdata at the edge.
  - Next state RESP.
- **IDLE, LS load:**
  - o_mem_addr = i_ls_addr.
  - i_mem_val is extended per size and unsigned flag, then registered into o_ls_rdata.
  - Byte extension uses [7:0]; halfword uses [15:0]; word is unchanged.
  - Next state RESP.
- **IDLE, LS word store:**
  - o_mem_wr_en=1; o_mem_wr_val = i_ls_wr_val.
  - Next state RESP.
- **IDLE, LS sub-word store:**
  - The read phase registers i_mem_val into rmw_buf.
  - Next state RMW_WR.
- **RMW_WR:**
  - o_mem_addr = i_ls_addr; o_mem_wr_en=1.
  - Byte store: o_mem_wr_val = {rmw_buf[31:8], i_ls_wr_val[7:0]}.
  - Halfword store: o_mem_wr_val = {rmw_buf[31:16], i_ls_wr_val[15:0]}.
  - Next state RESP.
- **RESP:**
  - The granted port's ack=1; memory idle (wr_en=0).
  - Requests are ignored this cycle.
  - Next state IDLE.
- A request still high in IDLE after its ack is treated as a new transaction.
- Addresses pass through unmodified; the memory handles unaligned byte addresses natively, so there is no alignment trapping.
- **Outputs and reset values:**
  - o_if_rdata, o_ls_rdata and rmw_buf are registered; reset value 0.
  - Acks reset to 0.
  - o_mem_wr_en is combinational from state and inputs, gated by !i_rst.

## Timing
- **Latency, request high in cycle N (state IDLE):**
  - Load or fetch: ack and data in N+1. Occupancy 2 cycles.
  - Word store: memory write at the end of N; ack in N+1.
  - Sub-word store: read in N, write at the end of N+1, ack in N+2. Occupancy 3 cycles.
- **Back-to-back:**
  - With both ports continuously requesting and STARVE_LIMIT=3, the grant pattern is LS, LS, LS, IF, repeating.
  - Max IF wait ≤ STARVE_LIMIT+1 transactions.
- Simultaneous requests: in IDLE, only the winner is served; the loser's request stays pending.
- Reset mid-RMW_WR: state returns to IDLE immediately; o_mem_wr_en drops within the same cycle; no partial write occurs after the reset edge.
- Acks never assert during or in the cycle following reset release without a new request.

## Test plan
- **Reset values:** reset asserted -> all outputs 0 and state IDLE; o_mem_wr_en=0 even with i_ls_req=1 and i_ls_wr_en=1.
- **IF fetch:** memory [0x10..0x13] = 13 12 11 10 and IF requests 0x10 -> o_if_ack one cycle later, o_if_rdata=0x10111213, then one idle RESP cycle.
- **Signed/unsigned byte load:** byte 0x80 at 0x20 -> signed load gives 0xFFFFFF80; unsigned load gives 0x00000080.
- **Byte store RMW:** word 0xAABBCCDD at 0x40, byte store of 0x11 to 0x40 -> write in the second cycle, ack in the third, then a load reads 0xAABBCC11.
- **Starvation guard:** both ports request continuously for 12 transactions with STARVE_LIMIT=3 -> grant order LS, LS, LS, IF repeated 3 times.
- **Reset mid-RMW:** assert i_rst during RMW_WR -> no write; memory is unchanged; no ack after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/LS requesters, the memory arbiter and the
// single-port main memory. The slave side is the arbiter; the master side
// is whatever drives the requests and models the memory.
interface mem_arbiter_if;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic [31:0] o_if_rdata;

    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic        i_ls_wr_en;
    logic [1:0]  i_ls_size;
    logic        i_ls_unsigned;
    logic [31:0] i_ls_wr_val;
    logic        o_ls_ack;
    logic [31:0] o_ls_rdata;

    logic [31:0] o_mem_addr;
    logic        o_mem_wr_en;
    logic [31:0] o_mem_wr_val;
    logic [31:0] i_mem_val;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_ack, o_if_rdata,
        input  i_ls_req, i_ls_addr, i_ls_wr_en, i_ls_size, i_ls_unsigned, i_ls_wr_val,
        output o_ls_ack, o_ls_rdata,
        output o_mem_addr, o_mem_wr_en, o_mem_wr_val,
        input  i_mem_val
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_ack, o_if_rdata,
        output i_ls_req, i_ls_addr, i_ls_wr_en, i_ls_size, i_ls_unsigned, i_ls_wr_val,
        input  o_ls_ack, o_ls_rdata,
        input  o_mem_addr, o_mem_wr_en, o_mem_wr_val,
        output i_mem_val
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port word memory between the
// instruction-fetch port and the load/store port. Sub-word stores are done
// as read-modify-write; loads are sign/zero extended. LS has priority unless
// IF has lost STARVE_LIMIT times in a row.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_starve;
    logic        r_gnt_ls;
    logic [31:0] r_if_rdata;
    logic [31:0] r_ls_rdata;
    logic [31:0] r_rmw_buf;

    logic        w_if_win;
    logic        w_ls_win;
    logic        w_if_gnt;
    logic        w_sub;
    logic [31:0] w_mem_addr;
    logic        w_wr_en;
    logic [31:0] w_wr_val;

    // Extend the addressed byte/halfword of a memory word to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic uns);
        logic [31:0] r;
        case (sz)
            2'b00:   r = uns ? {24'b0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   r = uns ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Splice the low store bytes into the word read during the RMW read phase.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wv,
                                          input logic [1:0] sz);
        logic [31:0] r;
        if (sz == 2'b00) r = {old[31:8], wv[7:0]};
        else             r = {old[31:16], wv[15:0]};
        return r;
    endfunction

    assign w_if_win = bus.i_if_req && (int'(r_starve) >= STARVE_LIMIT);
    assign w_ls_win = bus.i_ls_req && !w_if_win;
    assign w_if_gnt = bus.i_if_req && !w_ls_win;
    assign w_sub    = (bus.i_ls_size[1] == 1'b0);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and memory-side drive for the current transaction phase.
    always_comb begin
        w_next     = r_state;
        w_mem_addr = bus.i_if_addr;
        w_wr_en    = 1'b0;
        w_wr_val   = 32'b0;
        case (r_state)
            IDLE: begin
                if (w_ls_win) begin
                    w_mem_addr = bus.i_ls_addr;
                    if (bus.i_ls_wr_en && w_sub) begin
                        w_next = RMW_WR;
                    end else begin
                        w_wr_en  = bus.i_ls_wr_en;
                        w_wr_val = bus.i_ls_wr_en ? bus.i_ls_wr_val : 32'b0;
                        w_next   = RESP;
                    end
                end else if (w_if_gnt) begin
                    w_next = RESP;
                end
            end
            RMW_WR: begin
                w_mem_addr = bus.i_ls_addr;
                w_wr_en    = 1'b1;
                w_wr_val   = merge(r_rmw_buf, bus.i_ls_wr_val, bus.i_ls_size);
                w_next     = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant bookkeeping, starvation counter and read-data capture in IDLE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve   <= 2'd0;
            r_gnt_ls   <= 1'b0;
            r_if_rdata <= 32'b0;
            r_ls_rdata <= 32'b0;
            r_rmw_buf  <= 32'b0;
        end else if (r_state == IDLE) begin
            if (w_ls_win) begin
                r_gnt_ls <= 1'b1;
                if (!bus.i_ls_wr_en)
                    r_ls_rdata <= extend(bus.i_mem_val, bus.i_ls_size, bus.i_ls_unsigned);
                else if (w_sub)
                    r_rmw_buf <= bus.i_mem_val;
                if (bus.i_if_req)
                    r_starve <= (r_starve == 2'd3) ? 2'd3 : r_starve + 2'd1;
            end else if (w_if_gnt) begin
                r_gnt_ls   <= 1'b0;
                r_if_rdata <= bus.i_mem_val;
                r_starve   <= 2'd0;
            end
        end
    end

    assign bus.o_mem_addr   = w_mem_addr;
    assign bus.o_mem_wr_en  = w_wr_en && !i_rst;
    assign bus.o_mem_wr_val = w_wr_val;
    assign bus.o_if_ack     = (r_state == RESP) && !r_gnt_ls;
    assign bus.o_ls_ack     = (r_state == RESP) && r_gnt_ls;
    assign bus.o_if_rdata   = r_if_rdata;
    assign bus.o_ls_rdata   = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model and a
// queue of expected responses consumed as acks arrive.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Little-endian byte memory; read is combinational from o_mem_addr.
    bit   [7:0]  mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;

    function automatic logic [7:0] bidx(input logic [7:0] a, input int k);
        return a + k[7:0];
    endfunction

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {mem[bidx(a, 3)], mem[bidx(a, 2)], mem[bidx(a, 1)], mem[bidx(a, 0)]};
    endfunction

    always @(posedge clk) begin
        if (bus.o_mem_wr_en) begin
            for (int k = 0; k < 4; k++)
                mem[bidx(bus.o_mem_addr[7:0], k)] <= bus.o_mem_wr_val[8*k +: 8];
        end else if (pl_en) begin
            for (int k = 0; k < 4; k++)
                mem[bidx(pl_addr, k)] <= pl_data[8*k +: 8];
        end
    end

    always_comb bus.i_mem_val = {mem[bidx(bus.o_mem_addr[7:0], 3)], mem[bidx(bus.o_mem_addr[7:0], 2)],
                                 mem[bidx(bus.o_mem_addr[7:0], 1)], mem[bidx(bus.o_mem_addr[7:0], 0)]};

    typedef struct {
        logic        is_ls;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Starts at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic txn(input string tag, input logic is_ls, input logic [31:0] a,
                       input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] wv, input logic [31:0] exp_d,
                       input int exp_lat, input int exp_wcyc);
        int   n;
        int   wcyc;
        bit   got;
        exp_t e;
        if (is_ls) begin
            bus.i_ls_req      = 1'b1;
            bus.i_ls_addr     = a;
            bus.i_ls_wr_en    = wr;
            bus.i_ls_size     = sz;
            bus.i_ls_unsigned = uns;
            bus.i_ls_wr_val   = wv;
        end else begin
            bus.i_if_req  = 1'b1;
            bus.i_if_addr = a;
        end
        sb_q.push_back('{is_ls, !(is_ls && wr), exp_d});
        #1;
        wcyc = bus.o_mem_wr_en ? 0 : -1;
        n    = 0;
        got  = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (wcyc < 0 && bus.o_mem_wr_en) wcyc = n;
            if (bus.o_if_ack || bus.o_ls_ack) begin
                got = 1'b1;
                e   = sb_q.pop_front();
                chk({tag, "_port"}, {31'b0, bus.o_ls_ack}, {31'b0, e.is_ls});
                if (e.chk)
                    chk({tag, "_data"}, e.is_ls ? bus.o_ls_rdata : bus.o_if_rdata, e.data);
            end
        end
        if (!got) sb_q.delete();
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_wrcyc"}, wcyc, exp_wcyc);
        bus.i_ls_req = 1'b0;
        bus.i_if_req = 1'b0;
        @(negedge clk);
        chk({tag, "_noack"}, {30'b0, bus.o_if_ack, bus.o_ls_ack}, 32'h0);
    endtask

    initial begin
        int   cnt;
        int   nack;
        int   cyc;
        exp_t e;

        // Reset with an LS word store pending: nothing may be written.
        rst               = 1'b1;
        bus.i_if_req      = 1'b0;
        bus.i_if_addr     = 32'h0;
        bus.i_ls_req      = 1'b1;
        bus.i_ls_addr     = 32'h0;
        bus.i_ls_wr_en    = 1'b1;
        bus.i_ls_size     = 2'b10;
        bus.i_ls_unsigned = 1'b0;
        bus.i_ls_wr_val   = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_en",   {31'b0, bus.o_mem_wr_en}, 32'h0);
        chk("rst_acks",    {30'b0, bus.o_if_ack, bus.o_ls_ack}, 32'h0);
        chk("rst_if_rd",   bus.o_if_rdata, 32'h0);
        chk("rst_ls_rd",   bus.o_ls_rdata, 32'h0);
        chk("rst_addr",    bus.o_mem_addr, 32'h0);
        chk("rst_wr_val",  bus.o_mem_wr_val, 32'h0);
        rst          = 1'b0;
        bus.i_ls_req = 1'b0;
        @(negedge clk);
        chk("rel_acks", {30'b0, bus.o_if_ack, bus.o_ls_ack}, 32'h0);

        // IF fetch
        preload(8'h10, 32'h10111213);
        @(negedge clk);
        txn("if_fetch", 1'b0, 32'h10, 1'b0, 2'b10, 1'b0, 32'h0, 32'h10111213, 1, -1);

        // Signed / unsigned byte loads
        preload(8'h20, 32'h00000080);
        txn("lb_s", 1'b1, 32'h20, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1, -1);
        txn("lb_u", 1'b1, 32'h20, 1'b0, 2'b00, 1'b1, 32'h0, 32'h00000080, 1, -1);

        // Byte store RMW then readback
        preload(8'h40, 32'hAABBCCDD);
        txn("sb", 1'b1, 32'h40, 1'b1, 2'b00, 1'b0, 32'hDEADBE11, 32'h0, 2, 1);
        chk("sb_mem", rd_word(8'h40), 32'hAABBCC11);
        txn("lw_sb", 1'b1, 32'h40, 1'b0, 2'b10, 1'b0, 32'h0, 32'hAABBCC11, 1, -1);

        // Halfword store RMW and halfword/byte loads, including unaligned
        txn("sh", 1'b1, 32'h40, 1'b1, 2'b01, 1'b0, 32'h12347788, 32'h0, 2, 1);
        chk("sh_mem", rd_word(8'h40), 32'hAABB7788);
        txn("lh_s", 1'b1, 32'h42, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFFAABB, 1, -1);
        txn("lh_u", 1'b1, 32'h42, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000AABB, 1, -1);
        txn("lh_pos", 1'b1, 32'h40, 1'b0, 2'b01, 1'b0, 32'h0, 32'h00007788, 1, -1);
        txn("lbu_odd", 1'b1, 32'h41, 1'b0, 2'b00, 1'b1, 32'h0, 32'h00000077, 1, -1);

        // Word store (single cycle write) and size 11 load
        txn("sw", 1'b1, 32'h60, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1, 0);
        chk("sw_mem", rd_word(8'h60), 32'hCAFEF00D);
        txn("lw_sz3", 1'b1, 32'h60, 1'b0, 2'b11, 1'b0, 32'h0, 32'hCAFEF00D, 1, -1);

        // Starvation guard: both ports request for 12 transactions
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (cnt >= 3) begin
                sb_q.push_back('{1'b0, 1'b1, 32'h10111213});
                cnt = 0;
            end else begin
                sb_q.push_back('{1'b1, 1'b1, 32'hFFFFFF80});
                cnt = (cnt == 3) ? 3 : cnt + 1;
            end
        end
        bus.i_if_req      = 1'b1;
        bus.i_if_addr     = 32'h10;
        bus.i_ls_req      = 1'b1;
        bus.i_ls_addr     = 32'h20;
        bus.i_ls_wr_en    = 1'b0;
        bus.i_ls_size     = 2'b00;
        bus.i_ls_unsigned = 1'b0;
        nack = 0;
        cyc  = 0;
        while (nack < 12 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.o_if_ack || bus.o_ls_ack) begin
                e = sb_q.pop_front();
                chk($sformatf("starve_port%0d", nack), {31'b0, bus.o_ls_ack}, {31'b0, e.is_ls});
                chk($sformatf("starve_data%0d", nack),
                    e.is_ls ? bus.o_ls_rdata : bus.o_if_rdata, e.data);
                nack++;
            end
        end
        chk("starve_count", nack, 12);
        sb_q.delete();
        bus.i_if_req = 1'b0;
        bus.i_ls_req = 1'b0;
        @(negedge clk);

        // Reset during the RMW write phase
        preload(8'h80, 32'h55667788);
        bus.i_ls_req      = 1'b1;
        bus.i_ls_addr     = 32'h80;
        bus.i_ls_wr_en    = 1'b1;
        bus.i_ls_size     = 2'b00;
        bus.i_ls_wr_val   = 32'h00000099;
        @(negedge clk);
        #1;
        chk("rmw_pre_wr", {31'b0, bus.o_mem_wr_en}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rmw_rst_wr_en", {31'b0, bus.o_mem_wr_en}, 32'h0);
        @(negedge clk);
        rst          = 1'b0;
        bus.i_ls_req = 1'b0;
        chk("rmw_rst_mem", rd_word(8'h80), 32'h55667788);
        chk("rmw_rst_ls_rd", bus.o_ls_rdata, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmw_rel_noack%0d", i), {30'b0, bus.o_if_ack, bus.o_ls_ack}, 32'h0);
            chk($sformatf("rmw_rel_nowr%0d", i), {31'b0, bus.o_mem_wr_en}, 32'h0);
        end
        chk("rmw_final_mem", rd_word(8'h80), 32'h55667788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
